ex_mem_pipe_reg: RTL
====================

// Module: ex_mem_pipe_reg
// PURPOSE
//  Parametrised, elastic EX->MEM pipeline register for the five-stage core.
//  Carries the EX result bundle (WB/M control, branch target, zero, ALU result, store data, dest reg).
//  Adds valid/ready handshake, an optional 2-entry skid buffer, a synchronous flush and a bubble counter.
//  Also produces the registered branch-taken (PCSrc) signal consumed by IF.
// PARAMETERS
//  DATA_W   32  width of branch target, ALU result and store data
//  REG_W    5   destination register index width
//  SKID_EN  1   1: skid slot, in_ready fully registered; 0: single slot, ready passes through
//  CNT_W    16  width of the saturating bubble counter
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  flush        in   1       squash every held and incoming entry (synchronous)
//  in_valid     in   1       EX bundle valid
//  in_ready     out  1       stage can accept this cycle
//  ctl_wb_in    in   2       WB control {regwrite, memtoreg}
//  ctl_m_in     in   3       M control: [2]=branch, [1]=memwrite, [0]=memread
//  target_in    in   DATA_W  branch target address (adder output)
//  zero_in      in   1       ALU zero flag
//  alu_in       in   DATA_W  ALU result
//  store_in     in   DATA_W  register read data 2 (store data)
//  rd_in        in   REG_W   selected destination register
//  out_valid    out  1       MEM bundle valid
//  out_ready    in   1       MEM stage accepts this cycle
//  wb_ctl_out   out  2       WB control, 0 when !out_valid
//  branch, memwrite, memread  out 1 each   M control bits, 0 when !out_valid
//  target_out, alu_out, store_out  out DATA_W   held data
//  zero_out     out  1       held zero flag
//  rd_out       out  REG_W   held destination register
//  pcsrc        out  1       out_valid & branch & zero_out
//  bubble_cnt   out  CNT_W   cycles with out_valid==0 since reset, saturating
// BEHAVIOUR
//  - Reset (rst_n low, async): all state and outputs 0; out_valid=0, bubble_cnt=0; in_ready forced 0 while rst_n low.
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Latency: accepted bundle appears at outputs the next edge when main slot empty or draining.
//  - Main slot update priority: flush > (out_fire|!out_valid: load skid if skid valid, else input if in_fire) > hold.
//  - SKID_EN=1: in_ready = !skid_valid (registered, no comb path from out_ready).
//    in_fire while main occupied and !out_fire -> bundle goes to skid, in_ready drops next cycle.
//    out_fire with skid valid -> main<=skid, skid cleared, in_ready rises next cycle; input is not taken.
//    in_fire & out_fire with skid empty -> main<=input directly.
//  - SKID_EN=0: in_ready = out_ready | !out_valid; no skid state.
//  - Flush: next edge out_valid=0, skid cleared; an in_fire in the same cycle is dropped. Data regs may hold.
//  - Stall: out_valid & !out_ready holds every output bit-stable.
//  - Control gating: wb_ctl_out, branch, memwrite, memread, pcsrc are 0 whenever out_valid=0 (bubbles never write).
//  - Data outputs update only on load; no width conversion, bundles stored verbatim.
//  - bubble_cnt: +1 each edge where out_valid==0 (after reset release); saturates at 2^CNT_W-1, no wrap.
// TESTING
//  1 Reset mid-stream: assert rst_n=0 with both slots full -> out_valid=0, pcsrc=0, in_ready=0 immediately; 1 after release.
//  2 Pass-through: out_ready=1, send alu_in=0x0000_1234, rd_in=5, ctl_wb=2'b10 -> next cycle out_valid=1 with same values.
//  3 Skid: out_ready=0, send A then B -> A at outputs, B in skid, in_ready=0; raise out_ready -> A then B emitted, no loss/dup.
//  4 Branch: ctl_m_in=3'b100, zero_in=1, target_in=0x40 -> pcsrc=1, target_out=0x40 for one valid beat; zero_in=0 -> pcsrc=0.
//  5 Flush: flush=1 with main+skid full and in_fire -> next cycle out_valid=0, memwrite=0, in_ready=1; nothing later emitted.
//  6 Counter: CNT_W=4, hold in_valid=0 for 20 cycles -> bubble_cnt saturates at 15.

Source files
------------

// File: rtl/ex_mem_pipe_reg_if.sv
// EX->MEM bundle channel: valid/ready handshake plus the EX result fields on the
// input side and the held MEM-side fields on the output side.
interface ex_mem_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        ctl_wb_in;
  logic [2:0]        ctl_m_in;
  logic [DATA_W-1:0] target_in;
  logic              zero_in;
  logic [DATA_W-1:0] alu_in;
  logic [DATA_W-1:0] store_in;
  logic [REG_W-1:0]  rd_in;

  logic              out_valid;
  logic              out_ready;
  logic [1:0]        wb_ctl_out;
  logic              branch;
  logic              memwrite;
  logic              memread;
  logic [DATA_W-1:0] target_out;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] store_out;
  logic              zero_out;
  logic [REG_W-1:0]  rd_out;

  // Pipeline register side
  modport slave (
    input  in_valid, ctl_wb_in, ctl_m_in, target_in, zero_in, alu_in, store_in, rd_in,
    input  out_ready,
    output in_ready,
    output out_valid, wb_ctl_out, branch, memwrite, memread,
    output target_out, alu_out, store_out, zero_out, rd_out
  );

  // EX producer / MEM consumer side
  modport master (
    output in_valid, ctl_wb_in, ctl_m_in, target_in, zero_in, alu_in, store_in, rd_in,
    output out_ready,
    input  in_ready,
    input  out_valid, wb_ctl_out, branch, memwrite, memread,
    input  target_out, alu_out, store_out, zero_out, rd_out
  );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// Elastic EX->MEM pipeline register: main slot plus optional skid slot, synchronous
// flush, saturating bubble counter and registered-source branch-taken (pcsrc).
module ex_mem_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  ex_mem_pipe_reg_if.slave bus,
  output logic             pcsrc,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic [1:0]        wb;
    logic [2:0]        m;
    logic [DATA_W-1:0] target;
    logic              zero;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] store;
    logic [REG_W-1:0]  rd;
  } bundle_t;

  bundle_t          in_b;
  bundle_t          main_q;
  bundle_t          skid_q;
  logic             main_vld;
  logic             skid_vld;
  logic             in_ready_int;
  logic             in_fire;
  logic             out_fire;
  logic             load_main;
  logic [CNT_W-1:0] bub_q;

  assign in_b = {bus.ctl_wb_in, bus.ctl_m_in, bus.target_in, bus.zero_in,
                 bus.alu_in, bus.store_in, bus.rd_in};

  assign out_fire  = main_vld & bus.out_ready;
  assign load_main = out_fire | ~main_vld;
  assign in_fire   = bus.in_valid & in_ready_int;

  generate
    if (SKID_EN != 0) begin : g_skid
      logic rdy_q;

      // rdy_q always tracks !skid_vld of the next state, so in_ready has no
      // combinational path from out_ready.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          skid_vld <= 1'b0;
          skid_q   <= '0;
          rdy_q    <= 1'b0;
        end else if (flush) begin
          skid_vld <= 1'b0;
          rdy_q    <= 1'b1;
        end else if (load_main) begin
          skid_vld <= 1'b0;
          rdy_q    <= 1'b1;
        end else if (in_fire) begin
          skid_vld <= 1'b1;
          skid_q   <= in_b;
          rdy_q    <= 1'b0;
        end else begin
          rdy_q    <= ~skid_vld;
        end
      end

      assign in_ready_int = rdy_q;
    end else begin : g_noskid
      assign skid_vld     = 1'b0;
      assign skid_q       = '0;
      assign in_ready_int = rst_n & (bus.out_ready | ~main_vld);
    end
  endgenerate

  // A pending skid entry always wins over the input; in skid mode in_ready is
  // low whenever the skid slot is full, so no input is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      main_q   <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
    end else if (load_main) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
      end else if (in_fire) begin
        main_q   <= in_b;
        main_vld <= 1'b1;
      end else begin
        main_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bub_q <= '0;
    end else if (!main_vld && (bub_q != {CNT_W{1'b1}})) begin
      bub_q <= bub_q + CNT_W'(1);
    end
  end

  assign bubble_cnt = bub_q;

  assign bus.in_ready   = in_ready_int;
  assign bus.out_valid  = main_vld;

  // Control bits are gated so a bubble can never write memory or registers.
  assign bus.wb_ctl_out = main_vld ? main_q.wb : 2'b00;
  assign bus.branch     = main_vld & main_q.m[2];
  assign bus.memwrite   = main_vld & main_q.m[1];
  assign bus.memread    = main_vld & main_q.m[0];
  assign pcsrc          = main_vld & main_q.m[2] & main_q.zero;

  assign bus.target_out = main_q.target;
  assign bus.zero_out   = main_q.zero;
  assign bus.alu_out    = main_q.alu;
  assign bus.store_out  = main_q.store;
  assign bus.rd_out     = main_q.rd;

endmodule
